// File: rtl/seg_scan_ctrl.sv
// Digit-scan scheduler for the 6-digit price display: active-low digit rotation with
// blanking gap, per-group blink, and a frame-synchronous double buffer for the prices.
module seg_scan_ctrl #(
  parameter int unsigned SCAN_CYC     = 50000,
  parameter int unsigned BLANK_CYC    = 500,
  parameter int unsigned BLINK_FRAMES = 250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       disp_en,
  input  logic       upd_vld,
  output logic       upd_rdy,
  input  logic [6:0] price_put_in,
  input  logic [6:0] price_need_in,
  input  logic [6:0] price_out_in,
  input  logic [2:0] blink_en,
  output logic [5:0] sel,
  output logic [6:0] price_put,
  output logic [6:0] price_need,
  output logic [6:0] price_out,
  output logic       frame_done
);

  localparam int unsigned SHOW_CYC = SCAN_CYC - BLANK_CYC;
  localparam int unsigned CW       = $clog2(SCAN_CYC);
  localparam int unsigned FW       = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [CW-1:0] SHOW_LAST  = CW'(SHOW_CYC - 1);
  localparam logic [CW-1:0] SLOT_LAST  = CW'(SCAN_CYC - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHOW  = 2'd1;
  localparam logic [1:0] ST_BLANK = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          phase_q, phase_d;
  logic [5:0]    sel_q, sel_d;
  logic          frame_done_q, frame_done_d;
  logic          pending_q, pending_d;
  logic          upd_rdy_q, upd_rdy_d;
  logic [6:0]    sh_put_q, sh_put_d;
  logic [6:0]    sh_need_q, sh_need_d;
  logic [6:0]    sh_out_q, sh_out_d;
  logic [6:0]    put_q, put_d;
  logic [6:0]    need_q, need_d;
  logic [6:0]    out_q, out_d;
  logic          blink_hit;
  logic          capture;
  logic          commit;

  function automatic logic [6:0] sat99(input logic [6:0] v);
    return (v > 7'd99) ? 7'd99 : v;
  endfunction

  // Scan sequencing
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    fcnt_d  = fcnt_q;
    phase_d = phase_q;
    if (!disp_en) begin
      state_d = ST_IDLE;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_SHOW;
          idx_d   = '0;
          cnt_d   = '0;
        end
        ST_SHOW: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == SHOW_LAST) state_d = ST_BLANK;
        end
        ST_BLANK: begin
          if (cnt_q == SLOT_LAST) begin
            cnt_d   = '0;
            state_d = ST_SHOW;
            if (idx_q == 3'd5) begin
              idx_d = '0;
              if (fcnt_q == FRAME_LAST) begin
                fcnt_d  = '0;
                phase_d = ~phase_q;
              end else begin
                fcnt_d = fcnt_q + 1'b1;
              end
            end else begin
              idx_d = idx_q + 3'd1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          idx_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next-state values so the registered pins line up with the state
  always_comb begin
    case (idx_d)
      3'd0, 3'd1: blink_hit = blink_en[0];
      3'd2, 3'd3: blink_hit = blink_en[1];
      default:    blink_hit = blink_en[2];
    endcase
    sel_d = '1;
    if (state_d == ST_SHOW && !(phase_d && blink_hit)) sel_d = ~(6'b1 << idx_d);
    frame_done_d = (state_d == ST_BLANK) && (idx_d == 3'd5) && (cnt_d == SLOT_LAST);
  end

  // A capture can only happen with nothing pending, so it never lands in the current commit
  always_comb begin
    capture   = upd_vld && upd_rdy_q;
    commit    = pending_q && (frame_done_q || state_q == ST_IDLE);
    pending_d = pending_q;
    sh_put_d  = sh_put_q;
    sh_need_d = sh_need_q;
    sh_out_d  = sh_out_q;
    put_d     = put_q;
    need_d    = need_q;
    out_d     = out_q;
    if (capture) begin
      pending_d = 1'b1;
      sh_put_d  = sat99(price_put_in);
      sh_need_d = sat99(price_need_in);
      sh_out_d  = sat99(price_out_in);
    end else if (commit) begin
      pending_d = 1'b0;
      put_d     = sh_put_q;
      need_d    = sh_need_q;
      out_d     = sh_out_q;
    end
    upd_rdy_d = ~pending_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      fcnt_q       <= '0;
      phase_q      <= 1'b0;
      sel_q        <= '1;
      frame_done_q <= 1'b0;
      pending_q    <= 1'b0;
      upd_rdy_q    <= 1'b1;
      sh_put_q     <= '0;
      sh_need_q    <= '0;
      sh_out_q     <= '0;
      put_q        <= '0;
      need_q       <= '0;
      out_q        <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      fcnt_q       <= fcnt_d;
      phase_q      <= phase_d;
      sel_q        <= sel_d;
      frame_done_q <= frame_done_d;
      pending_q    <= pending_d;
      upd_rdy_q    <= upd_rdy_d;
      sh_put_q     <= sh_put_d;
      sh_need_q    <= sh_need_d;
      sh_out_q     <= sh_out_d;
      put_q        <= put_d;
      need_q       <= need_d;
      out_q        <= out_d;
    end
  end

  assign sel        = sel_q;
  assign frame_done = frame_done_q;
  assign upd_rdy    = upd_rdy_q;
  assign price_put  = put_q;
  assign price_need = need_q;
  assign price_out  = out_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: directed scenarios plus random traffic against a
// frame-position reference model.
module tb_seg_scan_ctrl;

  localparam int SCAN  = 8;
  localparam int BLANK = 2;
  localparam int BF    = 2;
  localparam int FRAME = 6 * SCAN;

  logic       clk = 1'b0;
  logic       rst, disp_en, upd_vld, upd_rdy, frame_done;
  logic [6:0] price_put_in, price_need_in, price_out_in;
  logic [6:0] price_put, price_need, price_out;
  logic [2:0] blink_en;
  logic [5:0] sel;

  always #5 clk = ~clk;

  seg_scan_ctrl #(.SCAN_CYC(SCAN), .BLANK_CYC(BLANK), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .rst(rst), .disp_en(disp_en), .upd_vld(upd_vld), .upd_rdy(upd_rdy),
    .price_put_in(price_put_in), .price_need_in(price_need_in), .price_out_in(price_out_in),
    .blink_en(blink_en), .sel(sel), .price_put(price_put), .price_need(price_need),
    .price_out(price_out), .frame_done(frame_done)
  );

  int compared   = 0;
  int mismatched = 0;

  // Reference model: scan position inside the frame and completed-frame count
  bit         m_running = 0;
  int         m_pos     = 0;
  int         m_frames  = 0;
  logic [5:0] m_sel     = 6'h3f;
  logic       m_fd      = 1'b0;
  logic       m_pending = 1'b0;
  logic       m_rdy     = 1'b1;
  logic [6:0] m_sh [3]  = '{7'd0, 7'd0, 7'd0};
  logic [6:0] m_pr [3]  = '{7'd0, 7'd0, 7'd0};

  function automatic logic [6:0] sat(input logic [6:0] v);
    if (v > 7'd99) return 7'd99;
    return v;
  endfunction

  task automatic model_step();
    bit commit, capture, phase, blinked;
    int digit, grp;
    if (rst) begin
      m_running = 0; m_pos = 0; m_frames = 0;
      m_pending = 0; m_rdy = 1;
      for (int k = 0; k < 3; k++) begin m_sh[k] = '0; m_pr[k] = '0; end
      m_sel = 6'h3f; m_fd = 0;
      return;
    end
    commit  = m_pending && (m_fd || !m_running);
    capture = upd_vld && m_rdy;
    if (capture) begin
      m_sh[0] = sat(price_put_in); m_sh[1] = sat(price_need_in); m_sh[2] = sat(price_out_in);
      m_pending = 1;
    end else if (commit) begin
      for (int k = 0; k < 3; k++) m_pr[k] = m_sh[k];
      m_pending = 0;
    end
    m_rdy = !m_pending;
    if (!disp_en) begin
      m_running = 0; m_pos = 0;
    end else if (!m_running) begin
      m_running = 1; m_pos = 0;
    end else if (m_pos == FRAME - 1) begin
      m_pos = 0; m_frames++;
    end else begin
      m_pos++;
    end
    digit   = m_pos / SCAN;
    grp     = digit / 2;
    phase   = ((m_frames / BF) % 2) == 1;
    blinked = phase && blink_en[grp];
    m_sel = 6'h3f;
    if (m_running && (m_pos % SCAN) < (SCAN - BLANK) && !blinked) m_sel = ~(6'b1 << digit);
    m_fd = m_running && (m_pos == FRAME - 1);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("sel", 32'(sel), 32'(m_sel));
    chk("frame_done", 32'(frame_done), 32'(m_fd));
    chk("upd_rdy", 32'(upd_rdy), 32'(m_rdy));
    chk("price_put", 32'(price_put), 32'(m_pr[0]));
    chk("price_need", 32'(price_need), 32'(m_pr[1]));
    chk("price_out", 32'(price_out), 32'(m_pr[2]));
  endtask

  initial begin
    int guard;
    int fd_cnt, c0, c2;
    rst = 1'b1; disp_en = 1'b0; upd_vld = 1'b0; blink_en = 3'b000;
    price_put_in = '0; price_need_in = '0; price_out_in = '0;
    @(negedge clk);
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("reset_sel", 32'(sel), 32'h3f);
    chk("reset_rdy", 32'(upd_rdy), 32'd1);
    chk("reset_put", 32'(price_put), 32'd0);
    chk("reset_fd", 32'(frame_done), 32'd0);

    // 1: basic rotation, one frame_done per 48 cycles
    disp_en = 1'b1;
    tick();
    chk("t1_first_digit", 32'(sel), 32'h3e);
    fd_cnt = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick();
      if (frame_done) fd_cnt++;
    end
    chk("t1_fd_count", 32'(fd_cnt), 32'd2);

    // 2: mid-frame update is held until frame end
    for (int i = 0; i < 10; i++) tick();
    upd_vld = 1'b1; price_put_in = 7'd35; price_need_in = 7'd25; price_out_in = 7'd10;
    tick();
    upd_vld = 1'b0;
    chk("t2_rdy_drop", 32'(upd_rdy), 32'd0);
    guard = 0;
    while (!m_fd && guard < 200) begin tick(); guard++; end
    chk("t2_fd_reached", 32'(frame_done), 32'd1);
    chk("t2_put_held", 32'(price_put), 32'd0);
    tick();
    chk("t2_put", 32'(price_put), 32'd35);
    chk("t2_need", 32'(price_need), 32'd25);
    chk("t2_out", 32'(price_out), 32'd10);
    chk("t2_rdy_back", 32'(upd_rdy), 32'd1);

    // 3: IDLE commit with saturation
    disp_en = 1'b0;
    tick();
    upd_vld = 1'b1; price_put_in = 7'd120; price_need_in = 7'd5; price_out_in = 7'd100;
    tick();
    upd_vld = 1'b0;
    tick(); tick();
    chk("t3_put_sat", 32'(price_put), 32'd99);
    chk("t3_need", 32'(price_need), 32'd5);
    chk("t3_out_sat", 32'(price_out), 32'd99);
    chk("t3_sel_off", 32'(sel), 32'h3f);

    // 4: blink on the need group over eight whole frames
    blink_en = 3'b010; disp_en = 1'b1;
    c0 = 0; c2 = 0;
    for (int i = 0; i < 8 * FRAME; i++) begin
      tick();
      if (sel == 6'b111110) c0++;
      if (sel == 6'b111011) c2++;
    end
    chk("t4_digit0_shown", 32'(c0), 32'd48);
    chk("t4_digit2_blinked", 32'(c2), 32'd24);

    // 5: disable during digit 3 SHOW, then restart from digit 0
    guard = 0;
    while (!(m_pos == 3 * SCAN + 2) && guard < 200) begin tick(); guard++; end
    chk("t5_digit3", 32'(sel), 32'(m_sel));
    disp_en = 1'b0; blink_en = 3'b000;
    tick();
    chk("t5_sel_off", 32'(sel), 32'h3f);
    fd_cnt = 0;
    for (int i = 0; i < 30; i++) begin tick(); if (frame_done) fd_cnt++; end
    chk("t5_no_fd", 32'(fd_cnt), 32'd0);
    disp_en = 1'b1;
    tick();
    chk("t5_restart", 32'(sel), 32'h3e);

    // 6: capture on the frame_done cycle defers a frame; reset drops it
    guard = 0;
    while (!m_fd && guard < 200) begin tick(); guard++; end
    chk("t6_fd_reached", 32'(frame_done), 32'd1);
    upd_vld = 1'b1; price_put_in = 7'd77; price_need_in = 7'd66; price_out_in = 7'd55;
    tick();
    upd_vld = 1'b0;
    chk("t6_put_not_bypassed", 32'(price_put), 32'd99);
    for (int i = 0; i < 20; i++) tick();
    chk("t6_still_pending", 32'(upd_rdy), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_rst_put", 32'(price_put), 32'd0);
    chk("t6_rst_rdy", 32'(upd_rdy), 32'd1);
    chk("t6_rst_sel", 32'(sel), 32'h3f);
    for (int i = 0; i < 60; i++) tick();
    chk("t6_discarded", 32'(price_put), 32'd0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 999) == 0);
      if ($urandom_range(0, 199) == 0) disp_en = ~disp_en;
      if ($urandom_range(0, 299) == 0) blink_en = 3'($urandom_range(0, 7));
      upd_vld = ($urandom_range(0, 19) == 0);
      price_put_in  = 7'($urandom_range(0, 127));
      price_need_in = 7'($urandom_range(0, 127));
      price_out_in  = 7'($urandom_range(0, 127));
      tick();
    end
    rst = 1'b0; upd_vld = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Scan scheduler for the 6-digit common-anode price display (put / need / out, two digits each). It generates the active-low digit-select rotation with an inter-digit blanking gap and per-group blinking. It double-buffers the three price values from the vending FSM so the display never tears mid-frame. It feeds sel and the latched prices to the segment decoder, which produces seg combinationally.

Parameters:
SCAN_CYC, 50000, clock cycles per digit slot (SHOW + BLANK); must be > BLANK_CYC
BLANK_CYC, 500, cycles at the end of each slot with all digits off (anti-ghosting); >= 1
BLINK_FRAMES, 250, full frames per blink half-period

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
disp_en  in  1  1 = scan display; 0 = all digits off
upd_vld  in  1  new price set offered
upd_rdy  out  1  shadow buffer free; transfer occurs when upd_vld && upd_rdy
price_put_in  in  7  money inserted
price_need_in  in  7  item price
price_out_in  in  7  change
blink_en  in  3  per-group blink: [0]=put (digits 0,1), [1]=need (2,3), [2]=out (4,5)
sel  out  6  digit select, active-low one-hot, 6'b111111 = all off
price_put  out  7  displayed put value (registered)
price_need  out  7  displayed need value (registered)
price_out  out  7  displayed change value (registered)
frame_done  out  1  one-cycle pulse at the end of digit 5's BLANK

Behaviour:
- All outputs registered.
- Reset values: sel=6'b111111, price_*=0, upd_rdy=1, frame_done=0. Internal reset values: state=IDLE, idx=0, slot counter=0, frame counter=0, blink phase=0, pending=0, shadow regs=0.
- FSM states: IDLE, SHOW, BLANK.
  - IDLE: sel=all-ones. When disp_en=1, go to SHOW with idx=0 on the next cycle.
  - SHOW: lasts SCAN_CYC-BLANK_CYC cycles. sel = ~(6'b1<<idx), i.e. idx0=111110 … idx5=011111. Exception: sel=all-ones when blink phase=1 and blink_en[idx/2]=1.
  - BLANK: lasts BLANK_CYC cycles with sel=all-ones. On its last cycle, idx increments. When idx=5 it instead wraps to 0, frame_done=1 for one cycle, and the frame counter increments. When the frame counter reaches BLINK_FRAMES-1, it clears and blink phase toggles.
- disp_en=0 in any state: next cycle IDLE, sel=all-ones, idx=0, slot counter=0. Frame and blink counters hold. No frame_done is issued.
- Update handshake:
  - Capture occurs on upd_vld && upd_rdy. Each input is saturated to 99 (values >99 store as 99).
  - The cycle after capture: pending=1, upd_rdy=0.
  - Commit: shadow is copied to price_* at the frame_done cycle. While in IDLE, commit happens on the cycle after capture.
  - After commit, pending=0 and upd_rdy=1 on the following cycle.
- Capture and frame end in the same cycle: the captured value waits for the next frame end. It never bypasses into the current commit.
- Values the FSM changes while upd_rdy=0 are the upstream's responsibility to hold with upd_vld. No drop or overwrite occurs inside this block.
- blink_en and disp_en are sampled every cycle with no latching.
- rst mid-frame: everything returns to reset values next cycle. A pending update is discarded.

Test Plan:
(Parameters for all scenarios: SCAN_CYC=8, BLANK_CYC=2, BLINK_FRAMES=2.)
1. Reset, then disp_en=1 -> sel cycles 111110×6, 111111×2, 111101×6, … 011111×6, 111111×2. frame_done pulses once every 48 cycles, coincident with the last all-ones cycle.
2. Mid-frame upd_vld with (put=35, need=25, out=10) -> upd_rdy drops the next cycle. price_* hold old values until the frame_done cycle, then show 35/25/10. upd_rdy=1 the cycle after.
3. disp_en=0, then upd_vld with put=120 -> price_put=99 two cycles after capture. sel stays 111111.
4. blink_en=3'b010 -> digits 2,3 show 111111 during SHOW in frames 3-4 and 7-8. Digits 0,1,4,5 are unaffected.
5. disp_en dropped during digit 3 SHOW -> sel=111111 next cycle, no frame_done. On re-enable, scan restarts at 111110.
6. upd_vld asserted on the frame_done cycle, then rst during pending -> commit deferred one frame. After rst: price_*=0, upd_rdy=1, sel=111111.
